// File: rtl/ifu_pkg.sv
//------------------------------------------------------------------------------
// Module  : ifu_pkg
// Brief   : Shared types and constants for the instruction fetch unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ifu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifu_entry_t;

endpackage : ifu_pkg

`default_nettype wire

// File: rtl/ifu_fifo.sv
//------------------------------------------------------------------------------
// Module  : ifu_fifo
// Brief   : Synchronous FIFO of PC-tagged instructions; flush beats push.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  ifu_entry_t    push_data,
   input  logic          pop,
   input  logic          flush,
   output ifu_entry_t    head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   ifu_entry_t    r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == C_LAST) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (r_count == '0);
   assign full      = (r_count == C_DEPTH);
   assign count     = r_count;
   assign head      = r_mem[r_rd];
   assign w_do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= ifu_entry_t'{pc: 32'h0, instr: NOP_INSTR};
         end
      end else if (flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr] <= push_data;
            r_wr        <= ptr_next(r_wr);
         end
         if (w_do_pop) begin
            r_rd <= ptr_next(r_rd);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule : ifu_fifo

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : instr_fetch_unit
// Brief   : PC-driven fetch initiator with credit-limited issue and a fetch
//           buffer; IFU_BYPASS_EN enables a same-cycle path around empty FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          IMEM_WORDS = 64,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        RE_mem1,
   output logic [31:0] mem_address,
   input  logic [31:0] Mem_out,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int            CW          = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0]   C_DEPTH     = (CW + 1)'(FIFO_DEPTH);
   localparam logic [31:0]   C_ADDR_MASK = 32'(IMEM_WORDS - 1);

   logic [31:0]   r_pc;
   logic [31:0]   r_req_pc;
   logic          r_inflight;
   logic          r_run;

   ifu_entry_t    w_head;
   ifu_entry_t    w_push_data;
   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_xfer;
   logic          w_bypass;
   logic          w_issue;
   logic [CW:0]   w_used;

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .flush     (redirect_valid),
      .head      (w_head),
      .count     (w_fifo_count),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );

`ifdef IFU_BYPASS_EN
   assign w_bypass = w_fifo_empty && r_inflight && !redirect_valid;
   assign if_valid = !w_fifo_empty || w_bypass;
   assign if_instr = w_bypass ? Mem_out  : w_head.instr;
   assign if_pc    = w_bypass ? r_req_pc : w_head.pc;
`else
   assign w_bypass = 1'b0;
   assign if_valid = !w_fifo_empty;
   assign if_instr = w_head.instr;
   assign if_pc    = w_head.pc;
`endif

   assign w_xfer      = if_valid && if_ready;
   assign w_pop       = !w_fifo_empty && if_ready && !redirect_valid;
   // The response landing in a redirect cycle belongs to the old path and is dropped by the flush.
   assign w_push      = r_inflight && !redirect_valid && !(w_bypass && if_ready);
   assign w_push_data = ifu_entry_t'{pc: r_req_pc, instr: Mem_out};

   // Buffered plus in-flight words may never exceed the buffer depth.
   assign w_used  = {1'b0, w_fifo_count}
                  + {{CW{1'b0}}, r_inflight}
                  - {{CW{1'b0}}, w_xfer};
   assign w_issue = r_run && !redirect_valid && (w_used < C_DEPTH)
                  && (!w_fifo_full || w_xfer);

   assign RE_mem1     = w_issue;
   assign mem_address = r_run ? ({2'b00, r_pc[31:2]} & C_ADDR_MASK) : 32'h0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= 32'h0;
         r_inflight <= 1'b0;
         r_run      <= 1'b0;
      end else begin
         r_run      <= 1'b1;
         r_inflight <= w_issue;
         if (redirect_valid) begin
            r_pc <= redirect_pc & ~32'h3;
         end else if (w_issue) begin
            r_pc     <= r_pc + 32'd4;
            r_req_pc <= r_pc;
         end
      end
   end

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_instr_fetch_unit
// Brief   : Randomized self-checking bench; a sequential-PC stream model checks
//           every accepted word, issue address and credit decision.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          IMEM_WORDS = 64;
   localparam int          FIFO_DEPTH = 2;
   localparam logic [31:0] C_MASK     = 32'(IMEM_WORDS - 1);
`ifdef IFU_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        RE_mem1;
   logic [31:0] mem_address;
   logic [31:0] Mem_out = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   logic [31:0] mem [IMEM_WORDS];

   int          n_cmp = 0;
   int          n_err = 0;

   // Reference model: accepted words follow a +4 PC sequence from the last reset/redirect.
   logic [31:0] exp_pc = RESET_PC;
   int          out_n = 0;
   bit          prev_rv = 1'b0;
   bit          hold = 1'b0;
   logic [31:0] hold_pc = 32'h0;
   logic [31:0] hold_instr = 32'h0;

   instr_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .IMEM_WORDS (IMEM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .RE_mem1        (RE_mem1),
      .mem_address    (mem_address),
      .Mem_out        (Mem_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (RE_mem1) Mem_out <= mem[mem_address[5:0]];
   end

   function automatic logic [31:0] exp_instr(input logic [31:0] pc);
      return 32'hA000_0000 + ((pc >> 2) & C_MASK);
   endfunction

   // Commit the model for the cycle just sampled, then drive the next cycle and stop at its negedge.
   task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      if (!rst) begin
         exp_pc = RESET_PC; out_n = 0; prev_rv = 1'b0; hold = 1'b0;
      end else if (redirect_valid) begin
         exp_pc = redirect_pc & ~32'h3; out_n = 0; prev_rv = 1'b1; hold = 1'b0;
      end else begin
         prev_rv    = 1'b0;
         hold       = if_valid && !if_ready;
         hold_pc    = if_pc;
         hold_instr = if_instr;
         if (RE_mem1) out_n++;
         if (if_valid && if_ready) begin exp_pc = exp_pc + 32'd4; out_n--; end
      end
      @(posedge clk);
      #2;
      rst = r; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      #3;
   endtask

   task automatic do_reset(input logic rdy);
      step(1'b0, rdy, 1'b0, 32'h0);
      step(1'b1, rdy, 1'b0, 32'h0);
   endtask

   task automatic test_stream(input int cycles, input int rdy_pct, input int rv_pct);
      for (int k = 0; k < cycles; k++) begin
         logic        rdy;
         logic        rv;
         logic [31:0] rpc;
         int          xfer_i;
         logic        exp_re;
         rdy = ($urandom_range(99) < rdy_pct);
         rv  = ($urandom_range(99) < rv_pct);
         rpc = $urandom();
         step(1'b1, rdy, rv, rpc);
         if (prev_rv) begin
            n_cmp++;
            if (if_valid !== 1'b0) begin
               n_err++; $display("FAIL post_redirect_valid: got %b expected 0", if_valid);
            end
         end
         if (hold) begin
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== hold_pc || if_instr !== hold_instr) begin
               n_err++;
               $display("FAIL hold_stable: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                        if_valid, if_pc, if_instr, hold_pc, hold_instr);
            end
         end
         xfer_i = (if_valid === 1'b1 && rdy) ? 1 : 0;
         exp_re = (!rv && (out_n - xfer_i < FIFO_DEPTH));
         n_cmp++;
         if (RE_mem1 !== exp_re) begin
            n_err++; $display("FAIL issue_decision: got RE=%b expected %b (outstanding %0d)", RE_mem1, exp_re, out_n);
         end
         if (RE_mem1 === 1'b1) begin
            n_cmp++;
            if (mem_address !== (((exp_pc + 32'(4 * out_n)) >> 2) & C_MASK)) begin
               n_err++;
               $display("FAIL issue_address: got %h expected %h", mem_address,
                        ((exp_pc + 32'(4 * out_n)) >> 2) & C_MASK);
            end
         end
         if (if_valid === 1'b1 && rdy && !rv) begin
            n_cmp++;
            if (if_pc !== exp_pc || if_instr !== exp_instr(exp_pc)) begin
               n_err++;
               $display("FAIL transfer: got pc=%h instr=%h expected pc=%h instr=%h",
                        if_pc, if_instr, exp_pc, exp_instr(exp_pc));
            end
         end
      end
   endtask

   task automatic test_reset;
      int first_k;
      step(1'b0, 1'b1, 1'b1, 32'h80);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (RE_mem1 !== 1'b0 || mem_address !== 32'h0 || if_valid !== 1'b0 ||
          if_instr !== 32'h0 || if_pc !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got re=%b addr=%h v=%b instr=%h pc=%h expected all zero",
                  RE_mem1, mem_address, if_valid, if_instr, if_pc);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (RE_mem1 !== 1'b0) begin
         n_err++; $display("FAIL re_first_cycle: got %b expected 0", RE_mem1);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (RE_mem1 !== 1'b1 || mem_address !== 32'h0) begin
         n_err++; $display("FAIL first_issue: got re=%b addr=%h expected re=1 addr=0", RE_mem1, mem_address);
      end
      first_k = BYP ? 0 : 1;
      for (int k = 0; k < 12; k++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         n_cmp++;
         if (k < first_k) begin
            if (if_valid !== 1'b0) begin
               n_err++; $display("FAIL latency_early: got v=%b expected 0 at k=%0d", if_valid, k);
            end
         end else if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== exp_instr(exp_pc)) begin
            n_err++;
            $display("FAIL throughput: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                     if_valid, if_pc, if_instr, exp_pc, exp_instr(exp_pc));
         end
      end
   endtask

   task automatic test_stall;
      int reads;
      do_reset(1'b0);
      reads = RE_mem1 ? 1 : 0;
      for (int k = 0; k < 7; k++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         if (RE_mem1) reads++;
         if (k >= 2) begin
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA000_0000) begin
               n_err++;
               $display("FAIL stall_head: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=a0000000",
                        if_valid, if_pc, if_instr);
            end
         end
      end
      n_cmp++;
      if (reads != FIFO_DEPTH || RE_mem1 !== 1'b0) begin
         n_err++; $display("FAIL stall_reads: got %0d reads re=%b expected %0d reads re=0", reads, RE_mem1, FIFO_DEPTH);
      end
      test_stream(20, 100, 0);
   endtask

   task automatic test_redirect;
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0043);
      n_cmp++;
      if (RE_mem1 !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
         n_err++; $display("FAIL redirect_cycle: got re=%b v=%b pc=%h expected re=0 v=1 pc=0", RE_mem1, if_valid, if_pc);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (if_valid !== 1'b0 || RE_mem1 !== 1'b1 || mem_address !== 32'h10) begin
         n_err++;
         $display("FAIL redirect_next: got v=%b re=%b addr=%h expected v=0 re=1 addr=10", if_valid, RE_mem1, mem_address);
      end
      test_stream(10, 100, 0);
   endtask

   task automatic test_wrap;
      do_reset(1'b1);
      step(1'b1, 1'b1, 1'b1, 32'h0000_00F0);
      test_stream(24, 100, 0);
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF5);
      test_stream(8, 100, 0);
   endtask

   task automatic test_reset_mid;
      do_reset(1'b1);
      test_stream(6, 100, 0);
      test_stream(4, 0, 0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (RE_mem1 !== 1'b0 || mem_address !== 32'h0 || if_valid !== 1'b0 ||
          if_instr !== 32'h0 || if_pc !== 32'h0) begin
         n_err++;
         $display("FAIL reset_midstream: got re=%b addr=%h v=%b instr=%h pc=%h expected all zero",
                  RE_mem1, mem_address, if_valid, if_instr, if_pc);
      end
      test_stream(10, 100, 0);
   endtask

   task automatic test_back_to_back;
      do_reset(1'b1);
      test_stream(6, 100, 0);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      n_cmp++;
      if (if_valid !== 1'b1) begin
         n_err++; $display("FAIL b2b_precondition: got v=%b expected 1", if_valid);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (if_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_flushed: got v=%b expected 0", if_valid);
      end
      test_stream(10, 100, 0);
   endtask

   task automatic test_random;
      do_reset(1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      test_stream(400, 60, 4);
      test_stream(200, 30, 2);
   endtask

   initial begin
      for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
      test_reset();
      test_stall();
      test_redirect();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_instr_fetch_unit

`default_nettype wire
